// File: rtl/pll_lock_supervisor_pkg.sv
// rtl/pll_lock_supervisor_pkg.sv - shared types and widths for the PLL lock supervisor
// Purpose: state encoding, counter widths and a small width helper.
// Ports: none (package).
package pll_lock_sup_pkg;

  // Encodings are visible on the debug/CSR state output and must not move.
  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_FAULT     = 3'd4
  } pll_sup_state_t;

  localparam int RETRY_CNT_W = 8;
  localparam int LOSS_CNT_W  = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// rtl/pll_lock_supervisor_if.sv - control/status bundle between supervisor and system
// Purpose: groups the PLL feedback, relock request and status signals.
// Signals: start, locked_async (into supervisor); pll_rst, pll_ready, fault,
//          retry_count, lock_loss_count, state (out of supervisor).
// Modports: master = supervisor side, slave = PLL/system side.
interface pll_lock_supervisor_if;
  import pll_lock_sup_pkg::*;

  logic                   start;
  logic                   locked_async;
  logic                   pll_rst;
  logic                   pll_ready;
  logic                   fault;
  logic [RETRY_CNT_W-1:0] retry_count;
  logic [LOSS_CNT_W-1:0]  lock_loss_count;
  logic [2:0]             state;

  modport master (
    input  start, locked_async,
    output pll_rst, pll_ready, fault, retry_count, lock_loss_count, state
  );

  modport slave (
    output start, locked_async,
    input  pll_rst, pll_ready, fault, retry_count, lock_loss_count, state
  );

endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// rtl/pll_lock_supervisor_sync_2ff.sv - generic single-bit two-flop synchronizer
// Purpose: brings an asynchronous level into the clk domain.
// Ports: clk, rst_n (async active-low), i_d (async input), o_q (synchronized).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - capture PLL reset/lock supervisor
// Purpose: pulses the PLL reset, waits for lock with a timeout, qualifies lock
//          as stable, retries a bounded number of times, then flags a fault.
// Ports: clk (50 MHz refclk), rst_n (async active-low),
//        bus (pll_lock_supervisor_if.master): start, locked_async in;
//        pll_rst, pll_ready, fault, retry_count, lock_loss_count, state out.
// Build option: PLL_LOCK_SUP_LOSS_CNT_EN enables the lock-loss counter;
//               without it lock_loss_count reads 8'h00.
module pll_lock_supervisor
  import pll_lock_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  pll_lock_supervisor_if.master  bus
);

  // One timer serves every timed state; it is cleared on each state entry.
  localparam int TW = max3($clog2(RST_PULSE_CYCLES), $clog2(LOCK_TIMEOUT_CYCLES),
                           $clog2(LOCK_STABLE_CYCLES));
  localparam logic [TW-1:0]          RST_LAST  = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0]          TO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]          STB_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_CNT_W-1:0] RETRY_MAX = RETRY_CNT_W'(MAX_RETRIES);

  logic                   w_locked_s;
  pll_sup_state_t         r_state;
  pll_sup_state_t         w_next_state;
  logic [TW-1:0]          r_timer;
  logic [TW-1:0]          w_timer_next;
  logic [RETRY_CNT_W-1:0] r_retry;
  logic [RETRY_CNT_W-1:0] w_retry_next;
  logic                   r_pll_rst;
  logic                   r_ready;
  logic                   r_fault;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.locked_async),
    .o_q   (w_locked_s)
  );

  always_comb begin
    w_next_state = r_state;
    w_timer_next = r_timer + 1'b1;
    w_retry_next = r_retry;
    if (bus.start) begin
      // Relock request wins over timeouts and lock loss in the same cycle.
      w_next_state = ST_RESET_PLL;
      w_timer_next = '0;
      w_retry_next = '0;
    end else begin
      case (r_state)
        ST_RESET_PLL: begin
          if (r_timer == RST_LAST) begin
            w_next_state = ST_WAIT_LOCK;
            w_timer_next = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_next_state = ST_STABLE;
            w_timer_next = '0;
          end else if (r_timer == TO_LAST) begin
            w_timer_next = '0;
            if (r_retry < RETRY_MAX) begin
              w_retry_next = r_retry + 1'b1;
              w_next_state = ST_RESET_PLL;
            end else begin
              w_next_state = ST_FAULT;
            end
          end
        end
        ST_STABLE: begin
          // A drop during qualification only restarts the wait; the PLL is
          // not reset and no retry is spent.
          if (!w_locked_s) begin
            w_next_state = ST_WAIT_LOCK;
            w_timer_next = '0;
          end else if (r_timer == STB_LAST) begin
            w_next_state = ST_READY;
            w_timer_next = '0;
          end
        end
        ST_READY: begin
          w_timer_next = '0;
          if (!w_locked_s) begin
            w_retry_next = '0;
            w_next_state = ST_RESET_PLL;
          end
        end
        ST_FAULT: begin
          w_timer_next = '0;
        end
        default: begin
          w_next_state = ST_RESET_PLL;
          w_timer_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RESET_PLL;
      r_timer   <= '0;
      r_retry   <= '0;
      r_pll_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_timer   <= w_timer_next;
      r_retry   <= w_retry_next;
      r_pll_rst <= (w_next_state == ST_RESET_PLL) || (w_next_state == ST_FAULT);
      r_ready   <= (w_next_state == ST_READY);
      r_fault   <= (w_next_state == ST_FAULT);
    end
  end

`ifdef PLL_LOCK_SUP_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  // Counts only READY-to-RESET_PLL drops; a simultaneous start suppresses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if (!bus.start && (r_state == ST_READY) && !w_locked_s &&
                 (r_loss_cnt != {LOSS_CNT_W{1'b1}})) begin
      r_loss_cnt <= r_loss_cnt + 1'b1;
    end
  end

  assign bus.lock_loss_count = r_loss_cnt;
`else
  assign bus.lock_loss_count = '0;
`endif

  assign bus.pll_rst     = r_pll_rst;
  assign bus.pll_ready   = r_ready;
  assign bus.fault       = r_fault;
  assign bus.retry_count = r_retry;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;
  import pll_lock_sup_pkg::*;

`ifdef PLL_LOCK_SUP_LOSS_CNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       start;
    logic       la;
    logic       rst;
    logic       rdy;
    logic       flt;
    logic [7:0] retry;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[19];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change at the falling edge; outputs are read at the next falling edge.
  task automatic step(input logic s, input logic la);
    bus.start        = s;
    bus.locked_async = la;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic s, input logic la, input logic r, input logic y,
                              input logic f, input logic [7:0] rc, input logic [2:0] st);
    vec_t v;
    v.start = s; v.la = la; v.rst = r; v.rdy = y; v.flt = f; v.retry = rc; v.st = st;
    return v;
  endfunction

  function automatic logic nl_rst(input int k);
    return (k < 4) || (k >= 24 && k < 28) || (k >= 48 && k < 52) || (k >= 72);
  endfunction

  function automatic logic [7:0] nl_retry(input int k);
    return (k < 24) ? 8'd0 : ((k < 48) ? 8'd1 : 8'd2);
  endfunction

  initial begin
    int cnt;
    int exp_loss;

    // Clean lock after reset release: one row per clock edge.
    tbl[0]  = mk(0, 0, 1, 0, 0, 0, 3'd0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 0, 3'd0);
    tbl[2]  = mk(0, 0, 1, 0, 0, 0, 3'd0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 3'd1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 3'd1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 3'd1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 3'd1);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 3'd1);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 3'd1);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 3'd2);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 3'd2);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 3'd2);
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 3'd2);
    tbl[13] = mk(0, 1, 0, 0, 0, 0, 3'd2);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 3'd2);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 3'd2);
    tbl[16] = mk(0, 1, 0, 0, 0, 0, 3'd2);
    tbl[17] = mk(0, 1, 0, 1, 0, 0, 3'd3);
    tbl[18] = mk(0, 1, 0, 1, 0, 0, 3'd3);

    bus.start        = 1'b0;
    bus.locked_async = 1'b0;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pll_rst", 32'(bus.pll_rst), 32'd1);
    check("rst_ready", 32'(bus.pll_ready), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_retry", 32'(bus.retry_count), 32'd0);
    check("rst_loss", 32'(bus.lock_loss_count), 32'd0);
    check("rst_state", 32'(bus.state), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].start, tbl[i].la);
      check($sformatf("clean_row%0d", i),
            32'({bus.pll_rst, bus.pll_ready, bus.fault, bus.retry_count, bus.state}),
            32'({tbl[i].rst, tbl[i].rdy, tbl[i].flt, tbl[i].retry, tbl[i].st}));
    end

    // Glitch during qualification: restart from READY with lock held.
    step(1, 1);
    cnt = bus.pll_rst ? 1 : 0;
    for (int k = 1; k <= 5; k++) begin
      step(0, 1);
      if (bus.pll_rst) cnt++;
    end
    check("glitch_pulse_len", 32'(cnt), 32'd4);
    check("glitch_stable_entry", 32'(bus.state), 32'd2);
    for (int p = 1; p <= 16; p++) begin
      step(0, (p != 5));
      check($sformatf("glitch_rst_p%0d", p), 32'(bus.pll_rst), 32'd0);
      check($sformatf("glitch_ready_p%0d", p), 32'(bus.pll_ready), 32'((p == 16) ? 1 : 0));
      if (p == 7) check("glitch_back_to_wait", 32'(bus.state), 32'd1);
      if (p == 8) check("glitch_restable", 32'(bus.state), 32'd2);
    end
    check("glitch_retry", 32'(bus.retry_count), 32'd0);

    // Never lock: three pulses, two retries, then fault held.
    step(1, 0);
    check("nl_k0_rst", 32'(bus.pll_rst), 32'd1);
    for (int k = 1; k < 80; k++) begin
      step(0, 0);
      check($sformatf("nl_rst_k%0d", k), 32'(bus.pll_rst), 32'(nl_rst(k)));
      check($sformatf("nl_retry_k%0d", k), 32'(bus.retry_count), 32'(nl_retry(k)));
      check($sformatf("nl_fault_k%0d", k), 32'(bus.fault), 32'((k >= 72) ? 1 : 0));
    end
    check("nl_fault_state", 32'(bus.state), 32'd4);

    // Start out of FAULT, then start in the cycle of the final timeout.
    step(1, 0);
    check("fault_exit_fault", 32'(bus.fault), 32'd0);
    check("fault_exit_retry", 32'(bus.retry_count), 32'd0);
    check("fault_exit_rst", 32'(bus.pll_rst), 32'd1);
    for (int k = 1; k < 72; k++) begin
      step(0, 0);
      check($sformatf("sp_rst_k%0d", k), 32'(bus.pll_rst), 32'(nl_rst(k)));
      if (k == 71) check("sp_retry_before", 32'(bus.retry_count), 32'd2);
    end
    step(1, 0);
    check("sp_state", 32'(bus.state), 32'd0);
    check("sp_retry", 32'(bus.retry_count), 32'd0);
    check("sp_fault", 32'(bus.fault), 32'd0);
    for (int k = 1; k < 60; k++) begin
      step(0, 0);
      check($sformatf("sp_nofault_k%0d", k), 32'(bus.fault), 32'd0);
      if (k < 5) check($sformatf("sp_pulse_k%0d", k), 32'(bus.pll_rst), 32'((k < 4) ? 1 : 0));
    end

    // Bring up to READY for the loss test.
    step(1, 1);
    for (int k = 0; k < 40 && !bus.pll_ready; k++) step(0, 1);
    check("loss_pre_ready", 32'(bus.pll_ready), 32'd1);

    // Loss while ready, repeated past saturation.
    for (int i = 1; i <= 260; i++) begin
      step(0, 0);
      if (i == 1) check("loss_ready_c1", 32'(bus.pll_ready), 32'd1);
      step(0, 0);
      if (i == 1) check("loss_ready_c2", 32'(bus.pll_ready), 32'd1);
      step(0, 0);
      if (i == 1) begin
        check("loss_ready_c3", 32'(bus.pll_ready), 32'd0);
        check("loss_rst_c3", 32'(bus.pll_rst), 32'd1);
      end
      exp_loss = LOSS_EN * ((i > 255) ? 255 : i);
      check($sformatf("loss_count_i%0d", i), 32'(bus.lock_loss_count), 32'(exp_loss));
      cnt = 1;
      for (int k = 0; k < 40 && !bus.pll_ready; k++) begin
        step(0, 1);
        if (bus.pll_rst) cnt++;
      end
      if (i == 1) check("loss_pulse_len", 32'(cnt), 32'd4);
      check($sformatf("loss_relock_i%0d", i), 32'(bus.pll_ready), 32'd1);
    end
    check("loss_retry", 32'(bus.retry_count), 32'd0);

    // Asynchronous reset while qualifying.
    step(1, 1);
    for (int k = 0; k < 20 && bus.state != 3'd2; k++) step(0, 1);
    step(0, 1);
    check("ar_in_stable", 32'(bus.state), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("ar_pll_rst", 32'(bus.pll_rst), 32'd1);
    check("ar_ready", 32'(bus.pll_ready), 32'd0);
    check("ar_fault", 32'(bus.fault), 32'd0);
    check("ar_retry", 32'(bus.retry_count), 32'd0);
    check("ar_loss", 32'(bus.lock_loss_count), 32'd0);
    check("ar_state", 32'(bus.state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1);
    check("ar_post_rst", 32'(bus.pll_rst), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
